// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 shift-add multiplier / restoring divider with MIPS HI/LO registers.
// Latency: WIDTH+1 edges from the accepting edge to HI/LO updated; done pulses the cycle after.
// Backpressure: busy is high while an operation runs; start, mthi and mtlo are dropped unless idle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;      // product / quotient must be negated at the end
    logic               neg_r;      // remainder must be negated at the end
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;      // dividend as issued, returned in HI on divide-by-zero
    logic [WIDTH-1:0]   m_op;       // multiplicand magnitude, or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}

    logic               in_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Operand magnitudes, one iteration step of each algorithm, and final sign correction
    always_comb begin
        in_signed = ~op[0];
        a_abs     = (in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_abs     = (in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m_op : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        ge        = (rem_shift >= {1'b0, m_op});
        diff      = rem_shift[WIDTH-1:0] - m_op;
        div_next  = {(ge ? diff : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], ge};

        prod_fix  = neg_q ? -acc : acc;
        quot_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            a_raw       <= '0;
            m_op        <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= '0;
                        is_div <= op[1];
                        neg_q  <= in_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        neg_r  <= in_signed & operand_a[WIDTH-1];
                        b_zero <= (operand_b == '0);
                        a_raw  <= operand_a;
                        m_op   <= op[1] ? b_abs : a_abs;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                    end else begin
                        // mthi / mtlo only when no operation is being issued
                        if (hi_write) hi <= write_data;
                        if (lo_write) lo <= write_data;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                    if (count == LAST) state <= FINISH;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div && b_zero) begin
                        hi          <= a_raw;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi          <= rem_fix;
                        lo          <= quot_fix;
                        div_by_zero <= 1'b0;
                    end else begin
                        {hi, lo}    <= prod_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clock = ~clock;

    // WIDTH=32 instance
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] operand_a = '0, operand_b = '0, write_data = '0;
    logic        hi_write = 1'b0, lo_write = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    // WIDTH=8 instance
    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'd0;
    logic [7:0]  a8 = '0, b8 = '0, wd8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int errors = 0;
    int checks = 0;

    mips_muldiv_unit #(.WIDTH(32)) u32 (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hi_write(hi_write), .lo_write(lo_write), .write_data(write_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    mips_muldiv_unit #(.WIDTH(8)) u8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .op(op8),
        .operand_a(a8), .operand_b(b8),
        .hi_write(1'b0), .lo_write(1'b0), .write_data(wd8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    // Architectural reference: MIPS mult/multu/div/divu semantics on w-bit operands
    function automatic void model(input int w, input logic [1:0] mop,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned mhi, output longint unsigned mlo,
                                  output bit mdbz);
        longint unsigned mask, up;
        longint sa, sb, sp, sq, sr;
        mask = (64'd1 << w) - 64'd1;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        mdbz = 1'b0;
        mhi = 0;
        mlo = 0;
        case (mop)
            2'd0: begin sp = sa * sb; up = sp; mhi = (up >> w) & mask; mlo = up & mask; end
            2'd1: begin up = a * b; mhi = (up >> w) & mask; mlo = up & mask; end
            default: begin
                if (b == 0) begin
                    mhi = a; mlo = mask; mdbz = 1'b1;
                end else if (mop == 2'd2) begin
                    sq = sa / sb; sr = sa % sb;
                    up = sq; mlo = up & mask;
                    up = sr; mhi = up & mask;
                end else begin
                    mlo = a / b; mhi = a % b;
                end
            end
        endcase
    endfunction

    // Drive start for one cycle from the current negedge; returns at the negedge after the accepting edge
    task automatic launch32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; operand_a = x; operand_b = y;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Wait for done, counting edges since the accepting edge and cycles with busy high
    task automatic wait32(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int lat, output int bcnt);
        @(negedge clock);
        launch32(o, x, y);
        wait32(lat, bcnt);
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int bcnt);
        @(negedge clock);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(negedge clock);
        start8 = 1'b0;
        lat = 0; bcnt = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            if (busy8 === 1'b1) bcnt++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [1:0]  to [6];
        logic [31:0] ta [6], tb [6], th [6], tl [6];
        logic        td [6];
        int lat, bcnt;
        to = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1};
        ta = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd100, 32'd2};
        tb = '{32'd5, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd3};
        th = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h64, 32'h0};
        tl = '{32'hFFFFFFF1, 32'h1, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd6};
        td = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            issue32(to[i], ta[i], tb[i], lat, bcnt);
            checks++; if (lat != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d want 33", i, lat); end
            checks++; if (bcnt != 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bcnt); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, busy); end
            checks++; if (hi !== th[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, th[i]); end
            checks++; if (lo !== tl[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, tl[i]); end
            checks++; if (div_by_zero !== td[i]) begin errors++; $display("FAIL dir%0d_dbz: got %b want %b", i, div_by_zero, td[i]); end
            @(negedge clock);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width: got %b want 0", i, done); end
            checks++; if (div_by_zero !== td[i]) begin errors++; $display("FAIL dir%0d_dbz_hold: got %b want %b", i, div_by_zero, td[i]); end
        end
    endtask

    task automatic test_random32();
        logic [1:0]  o;
        logic [31:0] x, y;
        longint unsigned mh, ml;
        bit md;
        int lat, bcnt;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: begin x = 32'($urandom_range(0, 100)); y = 32'($urandom_range(1, 10)); end
                3: y = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
                default: ;
            endcase
            model(32, o, x, y, mh, ml, md);
            issue32(o, x, y, lat, bcnt);
            checks++; if (lat != 33) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 33", i, lat); end
            checks++; if (hi !== mh[31:0]) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, x, y, hi, mh[31:0]); end
            checks++; if (lo !== ml[31:0]) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, x, y, lo, ml[31:0]); end
            checks++; if (div_by_zero !== md) begin errors++; $display("FAIL rnd%0d_dbz: got %b want %b", i, div_by_zero, md); end
        end
    endtask

    task automatic test_mthi_mtlo();
        int lat, bcnt;
        @(negedge clock);
        hi_write = 1'b1; write_data = 32'hCAFE0001;
        @(negedge clock);
        hi_write = 1'b0;
        checks++; if (hi !== 32'hCAFE0001) begin errors++; $display("FAIL mthi: got %h want cafe0001", hi); end
        hi_write = 1'b1; lo_write = 1'b1; write_data = 32'h0BADF00D;
        @(negedge clock);
        hi_write = 1'b0; lo_write = 1'b0;
        checks++; if (hi !== 32'h0BADF00D) begin errors++; $display("FAIL both_hi: got %h want 0badf00d", hi); end
        checks++; if (lo !== 32'h0BADF00D) begin errors++; $display("FAIL both_lo: got %h want 0badf00d", lo); end
        // start together with mthi/mtlo: the issue wins, HI/LO hold during the run
        hi_write = 1'b1; lo_write = 1'b1; write_data = 32'h11111111;
        launch32(2'd1, 32'd2, 32'd3);
        hi_write = 1'b0; lo_write = 1'b0;
        checks++; if (hi !== 32'h0BADF00D) begin errors++; $display("FAIL start_prio_hi: got %h want 0badf00d", hi); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_prio_busy: got %b want 1", busy); end
        repeat (3) @(negedge clock);
        lo_write = 1'b1; write_data = 32'h00001234;
        @(negedge clock);
        lo_write = 1'b0;
        checks++; if (lo !== 32'h0BADF00D) begin errors++; $display("FAIL mtlo_busy: got %h want 0badf00d", lo); end
        wait32(lat, bcnt);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL prio_result_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL prio_result_lo: got %h want 6", lo); end
    endtask

    task automatic test_start_while_busy();
        int dones;
        logic [31:0] rh, rl;
        dones = 0; rh = '0; rl = '0;
        @(negedge clock);
        launch32(2'd3, 32'd1000, 32'd7);
        for (int c = 0; c < 80; c++) begin
            if (done === 1'b1) begin dones++; rh = hi; rl = lo; end
            start = (c >= 4 && c < 8);
            op = 2'd1; operand_a = 32'd9; operand_b = 32'd9;
            @(negedge clock);
        end
        start = 1'b0;
        checks++; if (dones != 1) begin errors++; $display("FAIL busy_start_dones: got %0d want 1", dones); end
        checks++; if (rl !== 32'd142) begin errors++; $display("FAIL busy_start_lo: got %h want 8e", rl); end
        checks++; if (rh !== 32'd6) begin errors++; $display("FAIL busy_start_hi: got %h want 6", rh); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        longint unsigned mh, ml;
        bit md;
        issue32(2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, lat, bcnt);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
        // issue in the done cycle
        launch32(2'd2, 32'hFFFFFF9C, 32'd7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait32(lat, bcnt);
        model(32, 2'd2, 64'hFFFFFF9C, 64'd7, mh, ml, md);
        checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        checks++; if (lo !== ml[31:0]) begin errors++; $display("FAIL b2b_lo: got %h want %h", lo, ml[31:0]); end
        checks++; if (hi !== mh[31:0]) begin errors++; $display("FAIL b2b_hi: got %h want %h", hi, mh[31:0]); end
    endtask

    task automatic test_reset_midop();
        int dones;
        @(negedge clock);
        hi_write = 1'b1; write_data = 32'hAAAA5555;
        @(negedge clock);
        hi_write = 1'b0;
        launch32(2'd1, 32'd12345, 32'd678);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_lo: got %h want 0", lo); end
        @(negedge clock);
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 50; c++) begin
            if (done === 1'b1) dones++;
            @(negedge clock);
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", dones); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: got %b want 0", busy); end
    endtask

    task automatic test_width8();
        logic [1:0] o;
        logic [7:0] x, y;
        longint unsigned mh, ml;
        bit md;
        int lat, bcnt;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = 8'($urandom); y = 8'($urandom);
            case (i)
                0: begin o = 2'd2; x = 8'h80; y = 8'hFF; end
                1: begin o = 2'd0; x = 8'hFD; y = 8'h05; end
                2: begin o = 2'd2; x = 8'h85; y = 8'h00; end
                default: if ($urandom_range(0, 5) == 0) y = 8'h00;
            endcase
            model(8, o, x, y, mh, ml, md);
            issue8(o, x, y, lat, bcnt);
            checks++; if (lat != 9) begin errors++; $display("FAIL w8_%0d_latency: got %0d want 9", i, lat); end
            checks++; if (bcnt != 9) begin errors++; $display("FAIL w8_%0d_busy_cycles: got %0d want 9", i, bcnt); end
            checks++; if (hi8 !== mh[7:0]) begin errors++; $display("FAIL w8_%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, x, y, hi8, mh[7:0]); end
            checks++; if (lo8 !== ml[7:0]) begin errors++; $display("FAIL w8_%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, x, y, lo8, ml[7:0]); end
            checks++; if (dbz8 !== md) begin errors++; $display("FAIL w8_%0d_dbz: got %b want %b", i, dbz8, md); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random32();
        test_mthi_mtlo();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midop();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers for the MIPS_CPU datapath, implementing mult, multu, div, divu, mthi and mtlo. It sits beside the ALU: the control unit issues an operation with operands taken from the register file, and the unit runs a radix-2 shift-add / restoring-divide sequence over WIDTH cycles. It raises busy for the duration so the CPU can stall mfhi/mflo and new mul/div issues.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  issue request, sampled on rising edge; accepted only in IDLE.
- op  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu; sampled with start.
- operand_a  in  WIDTH  rs value: multiplicand or dividend.
- operand_b  in  WIDTH  rt value: multiplier or divisor.
- hi_write  in  1  mthi: HI ← write_data; honoured only in IDLE.
- lo_write  in  1  mtlo: LO ← write_data; honoured only in IDLE.
- write_data  in  WIDTH  data for mthi/mtlo.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  valid with done; high when the completed div/divu had operand_b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE → RUN on an edge with start=1.
  - Latch op.
  - Signed ops: latch |operand_a|, |operand_b| and the result signs.
  - Unsigned ops: latch operands raw.
  - Clear iteration counter.
- RUN: one iteration per edge, WIDTH iterations total; on the iteration with counter == WIDTH-1, go to FINISH.
  - Multiply: 2·WIDTH-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FINISH → IDLE on the next edge, which also does the following:
  - Sign-correct the results.
  - Write HI/LO.
  - Set done=1; set div_by_zero as appropriate.
- Result mapping:
  - mult/multu: {HI,LO} = full 2·WIDTH-bit product; signed product is two's complement.
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Signed most-negative ÷ −1: LO = most-negative value, HI = 0 (wraps, no flag).
  - Divisor 0: HI = operand_a (as latched, pre-abs), LO = all ones, div_by_zero = 1.
- mthi/mtlo:
  - Honoured only in IDLE, and only when start is not also asserted in that cycle; start has priority.
  - If hi_write and lo_write are both asserted, both registers are written.
  - Ignored in RUN/FINISH.
- start in RUN/FINISH is ignored; no queuing.
- HI/LO change only on FINISH, mthi/mtlo, or reset; they hold their old values during RUN.

## Timing
- Reset (asynchronous, reset_n=0): state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
- Reset asserted mid-operation aborts the operation; no done is produced.
- busy = (state != IDLE), registered.
- For start accepted at edge k:
  - busy=1 after edge k through edge k+WIDTH+1.
  - HI/LO are updated at edge k+WIDTH+1.
  - done=1 for exactly the cycle after edge k+WIDTH+1.
- Total latency: WIDTH+1 edges from the accepting edge to result visible.
- Back-to-back issue: a new start is accepted in the cycle where done=1, since the state is IDLE then.
- div_by_zero:
  - Updated only at FINISH (and cleared by reset).
  - Holds until the next FINISH.
  - Always 0 after mult/multu.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then mult with operand_a=0xFFFFFFFD (−3), operand_b=5 → done at edge k+33 (WIDTH=32); HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high for exactly 33 cycles.
- multu with 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, div_by_zero=0.
- Signed div −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Signed div 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu 100 ÷ 0 → HI=0x00000064, LO=0xFFFFFFFF, div_by_zero=1. A following multu 2×3 clears the flag: HI=0, LO=6.
- Protocol checks:
  - mtlo 0x1234 while busy → LO unchanged.
  - start again while busy → ignored, exactly one done.
  - start in the done cycle → accepted.
  - reset_n low at iteration 10 → busy=0, HI=LO=0 immediately, no done.
  - Repeat one case with WIDTH=8.
